// File: rtl/color_mapper_pkg.sv
// Shared types and helpers for the palette color mapper.
// Palette entries are {blink, rgb}.
package color_mapper_pkg;

  localparam int RGB_W       = 24;
  localparam int PAL_ENTRY_W = 25;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic blink;
    rgb_t rgb;
  } pal_entry_t;

  function automatic int unsigned pal_index(
    input int unsigned pattern,
    input int unsigned color,
    input int unsigned color_w
  );
    return (pattern << color_w) | color;
  endfunction

endpackage

// File: rtl/palette_color_mapper_ram.sv
// Palette storage: one write port, one synchronous read port.
// Read-before-write and no reset, so it maps onto block RAM.
module palette_ram
  import color_mapper_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  pal_entry_t        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output pal_entry_t        rdata
);

  pal_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/palette_color_mapper.sv
// Pattern/color code to RGB through a palette RAM, two-stage pipeline
// with background, transparency and frame-rate blinking.
module palette_color_mapper
  import color_mapper_pkg::*;
#(
  parameter int PATTERN_W        = 8,
  parameter int NUM_PATTERNS     = 16,
  parameter int COLOR_W          = 2,
  parameter int BLINK_FRAMES     = 30,
  parameter int TRANSPARENT_ZERO = 1
) (
  input  logic                                  Clk,
  input  logic                                  Reset,
  input  logic                                  pix_valid,
  input  logic [9:0]                            DrawX,
  input  logic [9:0]                            DrawY,
  input  logic [PATTERN_W-1:0]                  export_pattern,
  input  logic [COLOR_W-1:0]                    extend_color,
  input  logic                                  frame_start,
  input  logic                                  pal_we,
  input  logic [$clog2(NUM_PATTERNS)+COLOR_W-1:0] pal_addr,
  input  logic [PAL_ENTRY_W-1:0]                pal_wdata,
  input  logic                                  bg_we,
  input  logic [RGB_W-1:0]                      bg_wdata,
  output logic [7:0]                            VGA_R,
  output logic [7:0]                            VGA_G,
  output logic [7:0]                            VGA_B,
  output logic                                  pix_valid_out,
  output logic [9:0]                            DrawX_out,
  output logic [9:0]                            DrawY_out
);

  localparam int PIDX_W = $clog2(NUM_PATTERNS);
  localparam int ADDR_W = PIDX_W + COLOR_W;
  localparam int DEPTH  = NUM_PATTERNS << COLOR_W;
  localparam int CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [ADDR_W-1:0] rd_addr;
  pal_entry_t        rd_entry;
  logic              oor;
  logic              transp;

  assign rd_addr = ADDR_W'(pal_index(
    32'(export_pattern[PIDX_W-1:0]),
    32'(extend_color),
    COLOR_W));
  assign oor    = int'(export_pattern) >= NUM_PATTERNS;
  assign transp = (TRANSPARENT_ZERO != 0) && (extend_color == '0);

  palette_ram #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (Clk),
    .we    (pal_we),
    .waddr (pal_addr),
    .wdata (pal_wdata),
    .raddr (rd_addr),
    .rdata (rd_entry)
  );

  logic [CNT_W-1:0] frame_cnt;
  logic             blink_phase;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_start) begin
      if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  rgb_t bg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bg <= '0;
    end else if (bg_we) begin
      bg <= bg_wdata;
    end
  end

  logic       v1;
  logic [9:0] x1;
  logic [9:0] y1;
  logic       oor1;
  logic       transp1;
  logic       phase1;

  // Phase is captured with the pixel so a coincident toggle does not affect it
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      v1      <= 1'b0;
      x1      <= '0;
      y1      <= '0;
      oor1    <= 1'b0;
      transp1 <= 1'b0;
      phase1  <= 1'b1;
    end else begin
      v1      <= pix_valid;
      x1      <= DrawX;
      y1      <= DrawY;
      oor1    <= oor;
      transp1 <= transp;
      phase1  <= blink_phase;
    end
  end

  rgb_t pix;

  always_comb begin
    pix = '0;
    if (v1) begin
      if (oor1 || transp1 || (rd_entry.blink && !phase1)) begin
        pix = bg;
      end else begin
        pix = rd_entry.rgb;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      VGA_R         <= '0;
      VGA_G         <= '0;
      VGA_B         <= '0;
      pix_valid_out <= 1'b0;
      DrawX_out     <= '0;
      DrawY_out     <= '0;
    end else begin
      VGA_R         <= pix.r;
      VGA_G         <= pix.g;
      VGA_B         <= pix.b;
      pix_valid_out <= v1;
      DrawX_out     <= x1;
      DrawY_out     <= y1;
    end
  end

endmodule

// File: doc/palette_color_mapper.md
# palette_color_mapper

Parametrised, pipelined successor to the lab color mapper. Maps each pixel's pattern code and per-pixel color code through a writable palette RAM to 24-bit RGB, with background and transparency handling and per-entry frame-rate blinking. Sits between the sprite/tile pattern generator and the VGA output, driven by the pixel stream from the VGA controller.

## Interface

- `PATTERN_W`, default 8: width of the pattern (shape) code.
- `NUM_PATTERNS`, default 16: number of palette-backed patterns; codes at or above this value are out of range.
- `COLOR_W`, default 2: width of the per-pixel color code; each pattern has 2^COLOR_W palette entries.
- `BLINK_FRAMES`, default 30: number of frames per blink half-period; minimum 1.
- `TRANSPARENT_ZERO`, default 1: when 1, color code 0 is transparent.

Ports:

- `Clk` in 1: single clock; all logic is on its rising edge.
- `Reset` in 1: asynchronous, active-high.
- `pix_valid` in 1: the pixel on the inputs is in the visible area.
- `DrawX`, `DrawY` in 10 each: current pixel coordinates.
- `export_pattern` in PATTERN_W: pattern code for the pixel.
- `extend_color` in COLOR_W: color code within the pattern.
- `frame_start` in 1: one-cycle pulse at the start of each frame.
- `pal_we` in 1: palette write strobe.
- `pal_addr` in clog2(NUM_PATTERNS)+COLOR_W: palette address, formed as {pattern, color}.
- `pal_wdata` in 25: palette entry, {blink, R[7:0], G[7:0], B[7:0]}.
- `bg_we` in 1: background register write strobe.
- `bg_wdata` in 24: background RGB.
- `VGA_R`, `VGA_G`, `VGA_B` out 8 each: registered color outputs.
- `pix_valid_out` out 1: `pix_valid` delayed to align with the RGB outputs.
- `DrawX_out`, `DrawY_out` out 10 each: coordinates delayed to align with the RGB outputs.

## Operation

- **Lookup.** The palette address is {export_pattern[clog2(NUM_PATTERNS)-1:0], extend_color}, read synchronously.
- **Color selection at stage 2**, in priority order:
  - `pix_valid_out` = 0 → RGB = 0.
  - Pattern out of range (export_pattern ≥ NUM_PATTERNS) → background.
  - TRANSPARENT_ZERO = 1 and color code 0 → background.
  - Entry blink bit = 1 and `blink_phase` = 0 → background.
  - Otherwise → entry RGB.
- **Blink counter.**
  - `frame_cnt` counts `frame_start` pulses from 0 to BLINK_FRAMES-1.
  - On the pulse that would wrap it to 0, `blink_phase` toggles.
  - With BLINK_FRAMES = 1, the phase toggles on every `frame_start`.
- **Palette write.** Single cycle and always accepted. Palette contents are not cleared by `Reset`, so the RAM can infer as block RAM. Software must write every entry before use.
- **Background register.** Loads `bg_wdata` on `bg_we`.
- **Reset.** Asynchronous and valid mid-operation; all pipeline data in flight is discarded. Reset values:
  - `VGA_R/G/B` = 0, `pix_valid_out` = 0, `DrawX_out` = `DrawY_out` = 0.
  - Pipeline valid bits = 0.
  - `frame_cnt` = 0, `blink_phase` = 1 (visible).
  - Background = 0.

## Timing

- **Fixed latency of 2 cycles** from inputs to `VGA_*` and `pix_valid_out`, with no stalls and one pixel per cycle.
  - Edge 1: palette read and stage-1 registers (valid, coordinates, out-of-range flag, transparent flag).
  - Edge 2: output mux and output registers.
- **Write/read collision.** A palette write to the address read in the same cycle returns the old data (read-before-write). New data is seen by pixels presented from the next cycle.
- **Background write.** Applies to pixels reaching stage 2 on or after the edge following `bg_we`.
- **frame_start with a pixel.** A pixel presented in the same cycle as a `frame_start` that toggles `blink_phase` uses the pre-toggle phase. The phase is sampled at stage 1 and carried down the pipeline.
- **Blanking.** Back-to-back `pix_valid` toggling is honoured per pixel, with no bubbles.

## Structure

- **Package `color_mapper_pkg`:**
  - `rgb_t` packed struct {r, g, b}.
  - `pal_entry_t` {blink, rgb_t}.
  - `PAL_ENTRY_W` = 25 and `RGB_W` = 24.
  - Helper function `pal_index(pattern, color)`.
- **Sub-module `palette_ram`:** single-clock, one write port and one synchronous read port, read-before-write, depth NUM_PATTERNS·2^COLOR_W, no reset on the storage.
- **Top module:** address formation, blink counter, background register, 2-stage pipeline.

## Test plan

- **Reset mid-stream.** Assert `Reset` with valid pixels in flight → outputs are 0 immediately, `pix_valid_out` = 0, and the pipeline is empty for 2 cycles after release.
- **Basic lookup.** Write entry (pattern 3, color 2) = 0x0_12_34_56, then present pattern 3, color 2 with `pix_valid` = 1 → RGB = 12/34/56 exactly 2 cycles later, with DrawX/DrawY aligned.
- **Transparency and range.**
  - Background = 0x0000FF. Pattern 3, color 0 → 00/00/FF.
  - Pattern 20 with NUM_PATTERNS = 16 → 00/00/FF.
  - `pix_valid` = 0 → 00/00/00.
- **Blink.** BLINK_FRAMES = 2, entry blink = 1 with RGB FF/00/00.
  - Pulses 1 to 2 → visible, then background after the 2nd pulse.
  - Visible again after the 4th pulse.
  - A pixel coincident with the 2nd pulse is still FF/00/00.
- **Write collision.** Write 0xAABBCC to address A in the same cycle that address A is looked up (old value 0x112233) → that pixel outputs 11/22/33 and the next pixel outputs AA/BB/CC.
